// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and
// default sizing that matches the board divider.
package clk_period_meter_pkg;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_t;

  localparam int          DEFAULT_WIDTH      = 32;
  localparam logic [31:0] DEFAULT_MAX_CYCLES = 32'd200000000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a history flop that
// turns the synchronized level into a single-cycle rising-edge strobe.
module sync_edge_det
  import clk_period_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync_q;
  logic prev;

  // Synchronizer chain followed by the previous-level flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= async_in;
      sync_q <= meta;
      prev   <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow square wave in clk cycles.
// The first partial period after reset or timeout is discarded; results are
// published with a one-cycle meas_valid pulse on every later rising edge.
// The cycle counter saturates at MAX_CYCLES, so it can never wrap.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int          WIDTH      = DEFAULT_WIDTH,
  parameter logic [31:0] MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_CYCLES);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic level;
  logic rise;

  state_t           state, state_next;
  logic [WIDTH-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] hi_cnt, hi_cnt_next;
  logic [WIDTH-1:0] period_next;
  logic [WIDTH-1:0] high_time_next;
  logic             meas_valid_next;
  logic             timeout_next;

  sync_edge_det u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sig_in),
    .level    (level),
    .rise     (rise)
  );

  // State, counters and all outputs are registered here so outputs are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_EDGE;
      cnt        <= '0;
      hi_cnt     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      hi_cnt     <= hi_cnt_next;
      period     <= period_next;
      high_time  <= high_time_next;
      meas_valid <= meas_valid_next;
      timeout    <= timeout_next;
    end
  end

  // Next-state logic: a rise always wins over the cycle limit; in WAIT_EDGE cnt doubles as the idle timer.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    hi_cnt_next     = hi_cnt;
    period_next     = period;
    high_time_next  = high_time;
    meas_valid_next = 1'b0;
    timeout_next    = timeout;

    unique case (state)
      WAIT_EDGE: begin
        if (rise) begin
          state_next   = MEASURE;
          cnt_next     = ONE;
          hi_cnt_next  = ONE;
          timeout_next = 1'b0;
        end else if (cnt >= MAX_CNT) begin
          timeout_next = 1'b1;
        end else begin
          cnt_next    = cnt + ONE;
          hi_cnt_next = '0;
        end
      end

      MEASURE: begin
        if (rise) begin
          period_next     = cnt;
          high_time_next  = hi_cnt;
          meas_valid_next = 1'b1;
          cnt_next        = ONE;
          hi_cnt_next     = ONE;
          timeout_next    = 1'b0;
        end else if (cnt >= MAX_CNT) begin
          state_next   = WAIT_EDGE;
          timeout_next = 1'b1;
        end else begin
          cnt_next    = cnt + ONE;
          hi_cnt_next = hi_cnt + WIDTH'(level);
        end
      end

      default: begin
        state_next = WAIT_EDGE;
      end
    endcase
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: a table of steady waveforms plus
// hand-written sequences for timeout, restart, async reset and the
// rise/limit coincidence. sig inputs change on the falling clock edge.
module tb_clk_period_meter;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         sig_a;
  logic         sig_b;
  logic [W-1:0] period_a, high_time_a, period_b, high_time_b;
  logic         meas_valid_a, timeout_a, meas_valid_b, timeout_b;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  typedef struct {
    int per;
    int hi;
    int cyc;
  } meas_t;

  meas_t q[$];

  typedef struct {
    int hi;
    int lo;
    int nper;
    int exp_period;
    int exp_high;
    int exp_valids;
  } vec_t;

  vec_t vecs[5];

  clk_period_meter #(.WIDTH(W), .MAX_CYCLES(32'd50)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_a),
    .period     (period_a),
    .high_time  (high_time_a),
    .meas_valid (meas_valid_a),
    .timeout    (timeout_a)
  );

  clk_period_meter #(.WIDTH(W), .MAX_CYCLES(32'd10)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_b),
    .period     (period_b),
    .high_time  (high_time_b),
    .meas_valid (meas_valid_b),
    .timeout    (timeout_b)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp used to check spacing between measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every measurement of dut_a; reset empties the record.
  always @(negedge clk) begin
    if (rst) q.delete();
    else if (meas_valid_a) q.push_back('{per: int'(period_a), hi: int'(high_time_a), cyc: cyc});
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst   = 1'b1;
    sig_a = 1'b0;
    sig_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int hi, input int lo, input int nper);
    for (int p = 0; p < nper; p++) begin
      sig_a = 1'b1;
      repeat (hi) @(negedge clk);
      sig_a = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  initial begin
    int first_k, first_clear, first_valid, vp, vh, nv, saw_to;

    vecs[0] = '{hi: 5, lo: 5, nper: 4, exp_period: 10, exp_high: 5, exp_valids: 3};
    vecs[1] = '{hi: 4, lo: 4, nper: 5, exp_period: 8,  exp_high: 4, exp_valids: 4};
    vecs[2] = '{hi: 3, lo: 7, nper: 3, exp_period: 10, exp_high: 3, exp_valids: 2};
    vecs[3] = '{hi: 1, lo: 2, nper: 4, exp_period: 3,  exp_high: 1, exp_valids: 3};
    vecs[4] = '{hi: 2, lo: 1, nper: 3, exp_period: 3,  exp_high: 2, exp_valids: 2};

    rst   = 1'b1;
    sig_a = 1'b0;
    sig_b = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_period_a",  int'(period_a), 0);
    checkOutput("reset_high_a",    int'(high_time_a), 0);
    checkOutput("reset_valid_a",   int'(meas_valid_a), 0);
    checkOutput("reset_timeout_a", int'(timeout_a), 0);
    checkOutput("reset_period_b",  int'(period_b), 0);
    checkOutput("reset_timeout_b", int'(timeout_b), 0);
    rst = 1'b0;

    // Steady waveforms from a fresh reset: N rises give N-1 measurements.
    for (int v = 0; v < 5; v++) begin
      doReset();
      applyStimulus(vecs[v].hi, vecs[v].lo, vecs[v].nper);
      repeat (8) @(negedge clk);
      checkOutput($sformatf("vec%0d_count", v), q.size(), vecs[v].exp_valids);
      for (int i = 0; i < q.size(); i++) begin
        checkOutput($sformatf("vec%0d_period[%0d]", v, i), q[i].per, vecs[v].exp_period);
        checkOutput($sformatf("vec%0d_high[%0d]", v, i), q[i].hi, vecs[v].exp_high);
        if (i > 0)
          checkOutput($sformatf("vec%0d_spacing[%0d]", v, i), q[i].cyc - q[i-1].cyc, vecs[v].exp_period);
      end
      checkOutput($sformatf("vec%0d_timeout", v), int'(timeout_a), 0);
    end

    // Timeout: last rise then low forever; timeout appears 50 cycles after the detected rise.
    doReset();
    applyStimulus(5, 5, 2);
    sig_a   = 1'b1;
    first_k = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (timeout_a && first_k == 0) first_k = k;
      if (k == 5) sig_a = 1'b0;
    end
    checkOutput("timeout_latency", first_k, 53);
    checkOutput("timeout_period_hold", int'(period_a), 10);
    checkOutput("timeout_high_hold", int'(high_time_a), 5);
    checkOutput("timeout_valid_count", q.size(), 2);

    // Restart after timeout: cleared by the first rise, next valid one period later.
    sig_a       = 1'b1;
    first_clear = 0;
    first_valid = 0;
    vp          = 0;
    vh          = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!timeout_a && first_clear == 0) first_clear = k;
      if (meas_valid_a && first_valid == 0) begin
        first_valid = k;
        vp = int'(period_a);
        vh = int'(high_time_a);
      end
      sig_a = ((k % 10) < 5);
    end
    checkOutput("restart_clear_k", first_clear, 3);
    checkOutput("restart_valid_k", first_valid, 13);
    checkOutput("restart_period", vp, 10);
    checkOutput("restart_high", vh, 5);

    // Asynchronous reset between clock edges clears outputs immediately.
    checkOutput("prereset_period", int'(period_a), 10);
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_period", int'(period_a), 0);
    checkOutput("async_rst_high", int'(high_time_a), 0);
    checkOutput("async_rst_valid", int'(meas_valid_a), 0);
    checkOutput("async_rst_timeout", int'(timeout_a), 0);
    @(negedge clk);
    rst   = 1'b0;
    sig_a = 1'b0;
    @(negedge clk);
    sig_a       = 1'b1;
    first_valid = 0;
    saw_to      = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (meas_valid_a && first_valid == 0) first_valid = k;
      if (timeout_a) saw_to = 1;
      sig_a = ((k % 10) < 5);
    end
    checkOutput("post_rst_valid_k", first_valid, 13);
    checkOutput("post_rst_timeout", saw_to, 0);
    checkOutput("post_rst_period", int'(period_a), 10);

    // Constant low input on dut_a: idle timeout, no measurement.
    doReset();
    repeat (60) @(negedge clk);
    checkOutput("const_low_timeout", int'(timeout_a), 1);
    checkOutput("const_low_valids", q.size(), 0);

    // Period equal to the limit: rise wins, never a timeout.
    doReset();
    sig_b  = 1'b1;
    nv     = 0;
    saw_to = 0;
    for (int k = 1; k <= 59; k++) begin
      @(negedge clk);
      if (meas_valid_b) nv++;
      if (timeout_b) saw_to = 1;
      sig_b = ((k % 10) < 5);
    end
    checkOutput("limit_valids", nv, 5);
    checkOutput("limit_timeout", saw_to, 0);
    checkOutput("limit_period", int'(period_b), 10);
    checkOutput("limit_high", int'(high_time_b), 5);

    // Constant high input on dut_b: times out, never measures.
    doReset();
    sig_b = 1'b1;
    nv    = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (meas_valid_b) nv++;
    end
    checkOutput("const_high_valids", nv, 0);
    checkOutput("const_high_timeout", int'(timeout_b), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
